// File: rtl/ccff_bitstream_loader_if.sv
// ---------------------------------------------------------------------------
// ccff_bitstream_loader_if
// Host-side configuration port of the ccff bitstream loader.
//   start      : pulse, begin a load
//   abort      : pulse, terminate the current load
//   word_data  : bitstream word, MSB shifted into the chain first
//   word_valid : word_data is valid
//   word_ready : loader accepts the word this cycle
// master = host (SoC side), slave = loader.
// ---------------------------------------------------------------------------
interface ccff_bitstream_loader_if #(
    parameter int unsigned WORD_W = 32
) ();
    logic              start;
    logic              abort;
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output start,
        output abort,
        output word_data,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  start,
        input  abort,
        input  word_data,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/ccff_bitstream_loader.sv
// ---------------------------------------------------------------------------
// ccff_bitstream_loader
// Streams host bitstream words, MSB first, into the head of the FPGA
// configuration-chain (ccff) shift register and generates the chain's shift
// enable. Pads stay isolated (IO_ISOL_N = 0) until a full CHAIN_LEN-bit load
// has completed.
//
// Ports:
//   prog_clk, prog_reset_n : configuration clock, async active-low reset
//   host                   : start/abort and word valid/ready handshake
//   ccff_head              : serial config bit into the chain
//   ccff_shift_en          : chain clock enable (gates prog_clk at top level)
//   ccff_tail              : chain output (old contents)
//   tail_ones              : number of 1s observed on ccff_tail while shifting
//   bit_count              : bits shifted in the current/last load
//   IO_ISOL_N              : pad isolation release, 0 = isolated
//   busy, done             : load in progress / last load completed
// All outputs are registered.
// ---------------------------------------------------------------------------
module ccff_bitstream_loader #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned CHAIN_LEN = 1024,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                         prog_clk,
    input  logic                         prog_reset_n,
    ccff_bitstream_loader_if.slave       host,
    output logic                         ccff_head,
    output logic                         ccff_shift_en,
    input  logic                         ccff_tail,
    output logic [CNT_W-1:0]             tail_ones,
    output logic [CNT_W-1:0]             bit_count,
    output logic                         IO_ISOL_N,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned      IdxW     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] ChainLen = CNT_W'(CHAIN_LEN);
    localparam logic [IdxW-1:0]  TopIdx   = IdxW'(WORD_W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StShift,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              word_ready_q, word_ready_d;
    logic              head_q, head_d;
    logic              shift_en_q, shift_en_d;
    logic [CNT_W-1:0]  tail_ones_q, tail_ones_d;
    logic [CNT_W-1:0]  bit_count_q, bit_count_d;
    logic              isol_n_q, isol_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q      <= StIdle;
            sreg_q       <= '0;
            idx_q        <= '0;
            word_ready_q <= 1'b0;
            head_q       <= 1'b0;
            shift_en_q   <= 1'b0;
            tail_ones_q  <= '0;
            bit_count_q  <= '0;
            isol_n_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            idx_q        <= idx_d;
            word_ready_q <= word_ready_d;
            head_q       <= head_d;
            shift_en_q   <= shift_en_d;
            tail_ones_q  <= tail_ones_d;
            bit_count_q  <= bit_count_d;
            isol_n_q     <= isol_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        idx_d        = idx_q;
        word_ready_d = word_ready_q;
        head_d       = head_q;
        shift_en_d   = shift_en_q;
        tail_ones_d  = tail_ones_q;
        bit_count_d  = bit_count_q;
        isol_n_d     = isol_n_q;
        busy_d       = busy_q;
        done_d       = done_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (host.start) begin
                    state_d      = StFetch;
                    word_ready_d = 1'b1;
                    shift_en_d   = 1'b0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    isol_n_d     = 1'b0;
                    bit_count_d  = '0;
                    tail_ones_d  = '0;
                end
            end

            StFetch: begin
                if (host.abort) begin
                    state_d      = StIdle;
                    word_ready_d = 1'b0;
                    shift_en_d   = 1'b0;
                    busy_d       = 1'b0;
                    done_d       = 1'b0;
                    isol_n_d     = 1'b0;
                end else if (host.word_valid && word_ready_q) begin
                    // First bit goes straight to the head register so the
                    // chain captures it on the very next edge.
                    state_d      = StShift;
                    sreg_d       = host.word_data;
                    head_d       = host.word_data[WORD_W-1];
                    idx_d        = TopIdx;
                    word_ready_d = 1'b0;
                    shift_en_d   = 1'b1;
                end
            end

            StShift: begin
                if (host.abort) begin
                    // The bit launched this cycle is not counted; the chain
                    // contents are meaningless after an abort anyway.
                    state_d      = StIdle;
                    word_ready_d = 1'b0;
                    shift_en_d   = 1'b0;
                    busy_d       = 1'b0;
                    done_d       = 1'b0;
                    isol_n_d     = 1'b0;
                end else begin
                    // This edge is the enabled edge: the chain captures
                    // head_q and ccff_tail presents the bit leaving it.
                    if (bit_count_q != ChainLen) begin
                        bit_count_d = bit_count_q + 1'b1;
                    end
                    if (ccff_tail && (tail_ones_q != ChainLen)) begin
                        tail_ones_d = tail_ones_q + 1'b1;
                    end

                    if (bit_count_q >= ChainLen - 1'b1) begin
                        // Remaining low bits of a partial last word are dropped.
                        state_d    = StDone;
                        shift_en_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        isol_n_d   = 1'b1;
                    end else if (idx_q == '0) begin
                        state_d      = StFetch;
                        shift_en_d   = 1'b0;
                        word_ready_d = 1'b1;
                    end else begin
                        head_d = sreg_q[idx_q - 1'b1];
                        idx_d  = idx_q - 1'b1;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign host.word_ready = word_ready_q;
    assign ccff_head       = head_q;
    assign ccff_shift_en   = shift_en_q;
    assign tail_ones       = tail_ones_q;
    assign bit_count       = bit_count_q;
    assign IO_ISOL_N       = isol_n_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_bitstream_loader
// Directed bench for ccff_bitstream_loader with WORD_W=16, CHAIN_LEN=40.
// A behavioural 40-bit chain model sits on ccff_head/ccff_shift_en/ccff_tail
// and records the serial stream. Full loads come from a vector table; abort,
// abort-vs-word in FETCH and reset mid-shift are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_ccff_bitstream_loader;

    localparam int unsigned WORD_W    = 16;
    localparam int unsigned CHAIN_LEN = 40;
    localparam int unsigned CNT_W     = 6;

    logic             prog_clk = 1'b0;
    logic             prog_reset_n;
    logic             ccff_head;
    logic             ccff_shift_en;
    logic             ccff_tail;
    logic [CNT_W-1:0] tail_ones;
    logic [CNT_W-1:0] bit_count;
    logic             IO_ISOL_N;
    logic             busy;
    logic             done;

    ccff_bitstream_loader_if #(.WORD_W(WORD_W)) host_if ();

    ccff_bitstream_loader #(
        .WORD_W   (WORD_W),
        .CHAIN_LEN(CHAIN_LEN),
        .CNT_W    (CNT_W)
    ) dut (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .host         (host_if),
        .ccff_head    (ccff_head),
        .ccff_shift_en(ccff_shift_en),
        .ccff_tail    (ccff_tail),
        .tail_ones    (tail_ones),
        .bit_count    (bit_count),
        .IO_ISOL_N    (IO_ISOL_N),
        .busy         (busy),
        .done         (done)
    );

    always #5 prog_clk = ~prog_clk;

    // Chain model plus capture of every bit clocked into it.
    logic [39:0] chain = '0;
    logic [39:0] cap   = '0;
    int          cap_n = 0;
    logic        load_chain = 1'b0;
    logic [39:0] preload_val = '0;

    always @(posedge prog_clk) begin
        if (load_chain) begin
            chain <= preload_val;
            cap   <= '0;
            cap_n <= 0;
        end else if (ccff_shift_en) begin
            chain <= {chain[38:0], ccff_head};
            cap   <= {cap[38:0], ccff_head};
            cap_n <= cap_n + 1;
        end
    end

    assign ccff_tail = chain[39];

    typedef struct {
        logic [47:0] words;
        int          g1;
        int          g2;
        int          start_at;
        logic [39:0] preload;
        logic [39:0] exp_stream;
        int          exp_tail;
        int          exp_lat;
    } vec_t;

    vec_t vecs[4];

    int n_checks = 0;
    int n_err    = 0;
    int wi       = 0;
    int wait_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    // One host cycle: offer the next word when the loader is fetching,
    // holding back valid for the configured gap before words 2 and 3.
    task automatic drive_one(input logic [47:0] words, input int g1, input int g2);
        int   g;
        logic acc;
        g = (wi == 1) ? g1 : ((wi == 2) ? g2 : 0);
        if (host_if.word_ready && wi < 3) begin
            if (wait_cnt < g) begin
                host_if.word_valid = 1'b0;
                wait_cnt++;
            end else begin
                host_if.word_valid = 1'b1;
                host_if.word_data  = words[47 - 16*wi -: 16];
            end
        end else begin
            host_if.word_valid = 1'b0;
        end
        acc = host_if.word_valid && host_if.word_ready && !host_if.abort;
        step();
        if (acc) begin
            wi++;
            wait_cnt = 0;
        end
        host_if.word_valid = 1'b0;
    endtask

    task automatic preload_chain(input logic [39:0] val);
        preload_val = val;
        load_chain  = 1'b1;
        step();
        load_chain  = 1'b0;
    endtask

    task automatic begin_load();
        wi       = 0;
        wait_cnt = 0;
        host_if.start = 1'b1;
        step();
        host_if.start = 1'b0;
    endtask

    task automatic run_load(input int idx);
        int lat;
        preload_chain(vecs[idx].preload);
        begin_load();
        lat = 0;
        while (!done && lat < 200) begin
            if (vecs[idx].start_at != 0 && lat == vecs[idx].start_at) host_if.start = 1'b1;
            drive_one(vecs[idx].words, vecs[idx].g1, vecs[idx].g2);
            host_if.start = 1'b0;
            lat++;
        end
        check($sformatf("v%0d_done", idx), 64'(done), 64'd1);
        check($sformatf("v%0d_latency", idx), 64'(lat), 64'(vecs[idx].exp_lat));
        check($sformatf("v%0d_isol_n", idx), 64'(IO_ISOL_N), 64'd1);
        check($sformatf("v%0d_busy", idx), 64'(busy), 64'd0);
        check($sformatf("v%0d_bit_count", idx), 64'(bit_count), 64'd40);
        check($sformatf("v%0d_tail_ones", idx), 64'(tail_ones), 64'(vecs[idx].exp_tail));
        check($sformatf("v%0d_stream", idx), 64'(cap), 64'(vecs[idx].exp_stream));
        check($sformatf("v%0d_shift_cycles", idx), 64'(cap_n), 64'd40);
        check($sformatf("v%0d_shift_en_off", idx), 64'(ccff_shift_en), 64'd0);
        check($sformatf("v%0d_word_ready_off", idx), 64'(word_ready_now()), 64'd0);
    endtask

    function automatic logic word_ready_now();
        return host_if.word_ready;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_word_ready"}, 64'(host_if.word_ready), 64'd0);
        check({tag, "_head"}, 64'(ccff_head), 64'd0);
        check({tag, "_shift_en"}, 64'(ccff_shift_en), 64'd0);
        check({tag, "_tail_ones"}, 64'(tail_ones), 64'd0);
        check({tag, "_bit_count"}, 64'(bit_count), 64'd0);
        check({tag, "_isol_n"}, 64'(IO_ISOL_N), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        // Words A5F0,0FFF,C35A -> stream A5F0 0FFF C3 (low byte 5A dropped).
        // Latency counts edges after the start edge: 40 + 3 fetches, plus gaps.
        vecs[0] = '{48'hA5F0_0FFF_C35A, 0, 0, 10, 40'h00_0000_0000, 40'hA5F00FFFC3, 0, 43};
        vecs[1] = '{48'hA5F0_0FFF_C35A, 5, 0, 0, 40'h00_0000_1FFF, 40'hA5F00FFFC3, 13, 48};
        vecs[2] = '{48'hA5F0_0FFF_C35A, 5, 5, 25, 40'hF0_F0F0_0000, 40'hA5F00FFFC3, 12, 53};
        vecs[3] = '{48'hFFFF_0000_8001, 0, 2, 35, 40'hFF_FFFF_FFFF, 40'hFFFF000080, 40, 45};

        host_if.start      = 1'b0;
        host_if.abort      = 1'b0;
        host_if.word_valid = 1'b0;
        host_if.word_data  = '0;
        prog_reset_n       = 1'b1;
        #1 prog_reset_n = 1'b0;
        #2;
        check_all_zero("reset");
        repeat (2) @(posedge prog_clk);
        #3 prog_reset_n = 1'b1;
        step();

        for (int i = 0; i < 4; i++) begin
            run_load(i);
        end

        // Abort after 20 bits, then a fresh load must start from bit 0.
        preload_chain(40'h0);
        begin_load();
        for (int k = 0; k < 100 && bit_count != 6'd20; k++) begin
            drive_one(vecs[0].words, 0, 0);
        end
        check("abort_reached_20", 64'(bit_count), 64'd20);
        host_if.abort = 1'b1;
        drive_one(vecs[0].words, 0, 0);
        host_if.abort = 1'b0;
        check("abort_bit_count", 64'(bit_count), 64'd20);
        check("abort_done", 64'(done), 64'd0);
        check("abort_isol_n", 64'(IO_ISOL_N), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_shift_en", 64'(ccff_shift_en), 64'd0);
        repeat (3) step();
        check("abort_frozen", 64'(bit_count), 64'd20);
        run_load(0);

        // Abort and word_valid together in FETCH: word must not be taken.
        begin_load();
        check("fetch_ready", 64'(host_if.word_ready), 64'd1);
        host_if.word_valid = 1'b1;
        host_if.word_data  = 16'h1234;
        host_if.abort      = 1'b1;
        step();
        host_if.word_valid = 1'b0;
        host_if.abort      = 1'b0;
        check("fetch_abort_ready", 64'(host_if.word_ready), 64'd0);
        check("fetch_abort_shift_en", 64'(ccff_shift_en), 64'd0);
        check("fetch_abort_busy", 64'(busy), 64'd0);
        check("fetch_abort_bit_count", 64'(bit_count), 64'd0);
        step();
        check("fetch_abort_no_shift", 64'(ccff_shift_en), 64'd0);

        // Asynchronous reset in the middle of SHIFT.
        preload_chain(40'h0);
        begin_load();
        for (int k = 0; k < 100 && bit_count != 6'd10; k++) begin
            drive_one(vecs[0].words, 0, 0);
        end
        check("rst_reached_10", 64'(bit_count), 64'd10);
        check("rst_pre_shift_en", 64'(ccff_shift_en), 64'd1);
        #2 prog_reset_n = 1'b0;
        #1;
        check_all_zero("midrst");
        #2 prog_reset_n = 1'b1;
        step();
        step();
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_ready", 64'(host_if.word_ready), 64'd0);
        check("post_rst_isol_n", 64'(IO_ISOL_N), 64'd0);
        run_load(1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
